// File: rtl/fifo_rd_packer.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_rd_packer
//  Description : Read-side consumer of an asynchronous FIFO. Pops DSIZE-bit
//                words while the FIFO is non-empty, packs RATIO consecutive
//                words into one wide beat and presents it on a valid/ready
//                port. A flush request emits a partial beat with a lane mask.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_rd_packer #(
    parameter int DSIZE = 8,
    parameter int RATIO = 4
) (
    input  logic                     rclk,
    input  logic                     rrst_n,
    input  logic [DSIZE-1:0]         rdata,
    input  logic                     rempty,
    output logic                     rinc,
    input  logic                     flush,
    output logic [DSIZE*RATIO-1:0]   out_data,
    output logic [RATIO-1:0]         out_keep,
    output logic                     out_valid,
    input  logic                     out_ready
);

    localparam int               c_odw   = DSIZE * RATIO;
    localparam int               c_cw    = $clog2(RATIO + 1);
    localparam logic [c_cw-1:0]  c_ratio = c_cw'(RATIO);
    localparam logic [c_cw-1:0]  c_last  = c_cw'(RATIO - 1);
    localparam logic [c_cw-1:0]  c_one   = c_cw'(1);

    // Lane count: c_ratio means a complete word is parked in the accumulator
    logic [c_cw-1:0]   cnt_q, cnt_d;
    logic [c_odw-1:0]  acc_q, acc_d;
    logic              flush_pend_q, flush_pend_d;
    logic [c_odw-1:0]  data_q, data_d;
    logic [RATIO-1:0]  keep_q, keep_d;
    logic              valid_q, valid_d;

    logic              w_slot_free;
    logic              w_pop;
    logic              w_flush_req;
    logic [c_odw-1:0]  w_acc_wr;
    logic [c_odw-1:0]  w_data_part;
    logic [RATIO-1:0]  w_keep_part;

    // The output slot can take a new beat when empty or being drained now
    assign w_slot_free = !valid_q || out_ready;
    // Pop only while there is room in the accumulator and no flush is draining
    assign w_pop       = rrst_n && !rempty && (cnt_q < c_ratio) && !flush_pend_q;
    // A flush is serviced either from the pending bit or directly when no pop competes
    assign w_flush_req = flush_pend_q || flush;
    assign rinc        = w_pop;

    // Accumulator with the current FIFO word written into lane cnt; partial beat with unfilled lanes zeroed
    always_comb begin
        w_acc_wr    = acc_q;
        w_data_part = '0;
        w_keep_part = '0;
        for (int i = 0; i < RATIO; i++) begin
            if (cnt_q == c_cw'(i)) begin
                w_acc_wr[i*DSIZE +: DSIZE] = rdata;
            end
            if (c_cw'(i) < cnt_q) begin
                w_keep_part[i]                = 1'b1;
                w_data_part[i*DSIZE +: DSIZE] = acc_q[i*DSIZE +: DSIZE];
            end
        end
    end

    // Next-state: accumulate, bypass/transfer full words, service flushes, retire accepted beats
    always_comb begin
        logic load;
        load         = 1'b0;
        cnt_d        = cnt_q;
        acc_d        = acc_q;
        flush_pend_d = flush_pend_q;
        data_d       = data_q;
        keep_d       = keep_q;
        valid_d      = valid_q;

        if (w_pop) begin
            acc_d = w_acc_wr;
            // A flush alongside a pop is honoured after the popped word lands
            if (flush) begin
                flush_pend_d = 1'b1;
            end
            if (cnt_q == c_last) begin
                if (w_slot_free) begin
                    load   = 1'b1;
                    data_d = w_acc_wr;
                    keep_d = '1;
                    cnt_d  = '0;
                end else begin
                    cnt_d = c_ratio;
                end
            end else begin
                cnt_d = cnt_q + c_one;
            end
        end else if (cnt_q == c_ratio) begin
            if (w_slot_free) begin
                load         = 1'b1;
                data_d       = acc_q;
                keep_d       = '1;
                cnt_d        = '0;
                flush_pend_d = 1'b0;
            end else if (flush) begin
                flush_pend_d = 1'b1;
            end
        end else if (w_flush_req) begin
            if (cnt_q == '0) begin
                flush_pend_d = 1'b0;
            end else if (w_slot_free) begin
                load         = 1'b1;
                data_d       = w_data_part;
                keep_d       = w_keep_part;
                cnt_d        = '0;
                flush_pend_d = 1'b0;
            end else begin
                flush_pend_d = 1'b1;
            end
        end

        if (load) begin
            valid_d = 1'b1;
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

    // State registers; reset drops any partially packed data
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            cnt_q        <= '0;
            acc_q        <= '0;
            flush_pend_q <= 1'b0;
            data_q       <= '0;
            keep_q       <= '0;
            valid_q      <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            acc_q        <= acc_d;
            flush_pend_q <= flush_pend_d;
            data_q       <= data_d;
            keep_q       <= keep_d;
            valid_q      <= valid_d;
        end
    end

    assign out_data  = data_q;
    assign out_keep  = keep_q;
    assign out_valid = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_packer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_rd_packer
//  Description : Self-checking bench for fifo_rd_packer with a queue-based
//                reference model and directed plus randomized scenarios.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_rd_packer;

    localparam int DSIZE = 8;
    localparam int RATIO = 4;
    localparam int ODW   = DSIZE * RATIO;

    logic             rclk   = 1'b0;
    logic             rrst_n = 1'b0;
    logic [DSIZE-1:0] rdata;
    logic             rempty;
    logic             rinc;
    logic             flush  = 1'b0;
    logic [ODW-1:0]   out_data;
    logic [RATIO-1:0] out_keep;
    logic             out_valid;
    logic             out_ready = 1'b0;

    int checks = 0;
    int errors = 0;

    // Behavioural FIFO feeding the DUT
    logic [DSIZE-1:0] fifo_mem [0:8191];
    int               wr_ptr = 0;
    int               rd_ptr = 0;
    bit               drain  = 1'b0;

    assign rempty = (wr_ptr == rd_ptr);
    assign rdata  = rempty ? '0 : fifo_mem[rd_ptr[12:0]];

    fifo_rd_packer #(.DSIZE(DSIZE), .RATIO(RATIO)) dut (
        .rclk      (rclk),
        .rrst_n    (rrst_n),
        .rdata     (rdata),
        .rempty    (rempty),
        .rinc      (rinc),
        .flush     (flush),
        .out_data  (out_data),
        .out_keep  (out_keep),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 rclk = ~rclk;

    // Reference model: words gathered so far, pending flush, output register
    logic [DSIZE-1:0] m_acc [$];
    bit               m_pend = 1'b0;
    logic             m_ov   = 1'b0;
    logic [ODW-1:0]   m_od   = '0;
    logic [RATIO-1:0] m_ok   = '0;
    bit               chk_en = 1'b0;

    // Inputs sampled mid-cycle, consumed at the following rising edge
    logic             s_rinc  = 1'b0;
    logic             s_mrinc = 1'b0;
    logic             s_flush = 1'b0;
    logic             s_ready = 1'b0;
    logic [DSIZE-1:0] s_rdata = '0;

    function automatic logic [ODW-1:0] pack_acc();
        logic [ODW-1:0] d;
        d = '0;
        for (int i = 0; i < m_acc.size(); i++) begin
            d = d | (ODW'(m_acc[i]) << (i * DSIZE));
        end
        return d;
    endfunction

    // Emit whatever the model has gathered as one beat
    task automatic m_emit();
        int n;
        n     = m_acc.size();
        m_od  = pack_acc();
        m_ok  = RATIO'((1 << n) - 1);
        m_ov  = 1'b1;
        m_acc.delete();
    endtask

    // Model and FIFO update at each rising edge or reset
    initial begin
        forever begin
            @(posedge rclk or negedge rrst_n);
            if (drain) begin
                rd_ptr <= wr_ptr;
            end else if (s_rinc && rrst_n) begin
                rd_ptr <= rd_ptr + 1;
            end
            if (!rrst_n) begin
                m_acc.delete();
                m_pend = 1'b0;
                m_ov   = 1'b0;
                m_od   = '0;
                m_ok   = '0;
            end else begin
                bit slot;
                bit ld;
                slot = !m_ov || s_ready;
                ld   = 1'b0;
                if (s_mrinc) begin
                    m_acc.push_back(s_rdata);
                    if (s_flush) m_pend = 1'b1;
                    if (m_acc.size() == RATIO && slot) begin
                        m_emit();
                        ld = 1'b1;
                    end
                end else if (m_acc.size() == RATIO) begin
                    if (slot) begin
                        m_emit();
                        ld     = 1'b1;
                        m_pend = 1'b0;
                    end else if (s_flush) begin
                        m_pend = 1'b1;
                    end
                end else if (m_pend || s_flush) begin
                    if (m_acc.size() == 0) begin
                        m_pend = 1'b0;
                    end else if (slot) begin
                        m_emit();
                        ld     = 1'b1;
                        m_pend = 1'b0;
                    end else begin
                        m_pend = 1'b1;
                    end
                end
                if (!ld && m_ov && s_ready) m_ov = 1'b0;
            end
        end
    end

    // Mid-cycle lock-step comparison against the model, then sample inputs
    initial begin
        forever begin
            @(negedge rclk);
            s_mrinc = rrst_n && !rempty && (m_acc.size() < RATIO) && !m_pend;
            if (chk_en) begin
                checks++;
                if (rinc !== s_mrinc) begin
                    errors++;
                    $display("FAIL mon_rinc @%0t: got %b want %b", $time, rinc, s_mrinc);
                end
                checks++;
                if (out_valid !== m_ov) begin
                    errors++;
                    $display("FAIL mon_valid @%0t: got %b want %b", $time, out_valid, m_ov);
                end
                checks++;
                if (out_data !== m_od) begin
                    errors++;
                    $display("FAIL mon_data @%0t: got %h want %h", $time, out_data, m_od);
                end
                checks++;
                if (out_keep !== m_ok) begin
                    errors++;
                    $display("FAIL mon_keep @%0t: got %b want %b", $time, out_keep, m_ok);
                end
            end
            s_rinc  = rinc;
            s_flush = flush;
            s_ready = out_ready;
            s_rdata = rdata;
        end
    end

    task automatic tick();
        @(posedge rclk);
        #1;
    endtask

    task automatic push(input logic [DSIZE-1:0] w);
        fifo_mem[wr_ptr[12:0]] = w;
        wr_ptr++;
    endtask

    task automatic do_reset();
        rrst_n    = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        drain     = 1'b1;
        tick();
        tick();
        drain  = 1'b0;
        rrst_n = 1'b1;
    endtask

    task automatic test_reset();
        rrst_n = 1'b0;
        tick();
        push(8'h5A);
        #2;
        checks++;
        if (rinc !== 1'b0) begin errors++; $display("FAIL reset_rinc: got %b want 0", rinc); end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        checks++;
        if (out_data !== '0) begin errors++; $display("FAIL reset_data: got %h want 0", out_data); end
        checks++;
        if (out_keep !== '0) begin errors++; $display("FAIL reset_keep: got %b want 0", out_keep); end
        do_reset();
    endtask

    task automatic test_streaming();
        logic [ODW-1:0] beats [0:7];
        int pops, nb, run, best;
        pops = 0; nb = 0; run = 0; best = 0;
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) push(DSIZE'(i));
        for (int c = 0; c < 12; c++) begin
            @(negedge rclk);
            if (rinc) begin pops++; run++; if (run > best) best = run; end
            else run = 0;
            if (out_valid && nb < 8) begin beats[nb] = out_data; nb++; end
        end
        checks++;
        if (best != 8) begin errors++; $display("FAIL stream_rinc_run: got %0d want 8", best); end
        checks++;
        if (nb != 2) begin errors++; $display("FAIL stream_beats: got %0d want 2", nb); end
        checks++;
        if (beats[0] !== 32'h04030201) begin errors++; $display("FAIL stream_beat0: got %h want 04030201", beats[0]); end
        checks++;
        if (beats[1] !== 32'h08070605) begin errors++; $display("FAIL stream_beat1: got %h want 08070605", beats[1]); end
        checks++;
        if (out_keep !== 4'b1111) begin errors++; $display("FAIL stream_keep: got %b want 1111", out_keep); end
        do_reset();
    endtask

    task automatic test_backpressure();
        logic [ODW-1:0] exp [0:2];
        int pops, nb;
        exp[0] = 32'h23222120; exp[1] = 32'h27262524; exp[2] = 32'h2B2A2928;
        pops = 0; nb = 0;
        out_ready = 1'b0;
        for (int i = 0; i < 12; i++) push(DSIZE'(8'h20 + i));
        for (int c = 0; c < 16; c++) begin
            @(negedge rclk);
            if (rinc) pops++;
            if (out_valid) begin
                checks++;
                if (out_data !== exp[0]) begin errors++; $display("FAIL bp_hold: got %h want %h", out_data, exp[0]); end
            end
        end
        checks++;
        if (pops != 8) begin errors++; $display("FAIL bp_pops: got %0d want 8", pops); end
        checks++;
        if (rinc !== 1'b0) begin errors++; $display("FAIL bp_stall: got %b want 0", rinc); end
        tick();
        out_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge rclk);
            if (out_valid && out_ready) begin
                checks++;
                if (nb > 2 || out_data !== exp[nb > 2 ? 2 : nb]) begin
                    errors++;
                    $display("FAIL bp_order: beat %0d got %h want %h", nb, out_data, exp[nb > 2 ? 2 : nb]);
                end
                nb++;
            end
        end
        checks++;
        if (nb != 3) begin errors++; $display("FAIL bp_count: got %0d want 3", nb); end
        do_reset();
    endtask

    task automatic test_partial_flush();
        int nb;
        nb = 0;
        out_ready = 1'b1;
        push(8'hAA);
        push(8'hBB);
        for (int c = 0; c < 4; c++) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        @(negedge rclk);
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL pflush_valid: got %b want 1", out_valid); end
        checks++;
        if (out_data !== 32'h0000BBAA) begin errors++; $display("FAIL pflush_data: got %h want 0000bbaa", out_data); end
        checks++;
        if (out_keep !== 4'b0011) begin errors++; $display("FAIL pflush_keep: got %b want 0011", out_keep); end
        tick();
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        for (int c = 0; c < 8; c++) begin
            @(negedge rclk);
            if (out_valid) begin
                nb++;
                checks++;
                if (out_data !== 32'h44332211) begin errors++; $display("FAIL pflush_resume: got %h want 44332211", out_data); end
            end
        end
        checks++;
        if (nb != 1) begin errors++; $display("FAIL pflush_resume_count: got %0d want 1", nb); end
        do_reset();
    endtask

    task automatic test_empty_full_flush();
        int nv, nb;
        nv = 0; nb = 0;
        out_ready = 1'b1;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge rclk);
            if (out_valid) nv++;
        end
        checks++;
        if (nv != 0) begin errors++; $display("FAIL eflush_nobeat: got %0d want 0", nv); end
        tick();
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) push(DSIZE'(8'h50 + i));
        for (int c = 0; c < 10; c++) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge rclk);
            if (out_valid) begin
                checks++;
                if (out_keep !== 4'b1111) begin errors++; $display("FAIL fflush_keep: got %b want 1111", out_keep); end
                checks++;
                if (out_data !== (nb == 0 ? 32'h53525150 : 32'h57565554)) begin
                    errors++;
                    $display("FAIL fflush_data: beat %0d got %h", nb, out_data);
                end
                nb++;
            end
        end
        checks++;
        if (nb != 2) begin errors++; $display("FAIL fflush_count: got %0d want 2", nb); end
        do_reset();
    endtask

    task automatic test_flush_with_pop();
        int nb;
        nb = 0;
        out_ready = 1'b1;
        push(8'h61); push(8'h62); push(8'h63);
        tick();
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge rclk);
            if (out_valid) begin
                nb++;
                checks++;
                if (out_keep !== 4'b0111) begin errors++; $display("FAIL fpop_keep: got %b want 0111", out_keep); end
                checks++;
                if (out_data !== 32'h00636261) begin errors++; $display("FAIL fpop_data: got %h want 00636261", out_data); end
            end
        end
        checks++;
        if (nb != 1) begin errors++; $display("FAIL fpop_count: got %0d want 1", nb); end
        do_reset();
    endtask

    task automatic test_reset_mid();
        int nb;
        nb = 0;
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) push(DSIZE'(8'h70 + i));
        for (int c = 0; c < 8; c++) tick();
        rrst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid: got %b want 0", out_valid); end
        checks++;
        if (out_data !== '0) begin errors++; $display("FAIL rmid_data: got %h want 0", out_data); end
        checks++;
        if (out_keep !== '0 || rinc !== 1'b0) begin
            errors++; $display("FAIL rmid_keep_rinc: got keep %b rinc %b want 0000 0", out_keep, rinc);
        end
        tick();
        rrst_n = 1'b1;
        out_ready = 1'b1;
        push(8'h80); push(8'h81); push(8'h82); push(8'h83);
        for (int c = 0; c < 8; c++) begin
            @(negedge rclk);
            if (out_valid) begin
                nb++;
                checks++;
                if (out_data !== 32'h83828180 || out_keep !== 4'b1111) begin
                    errors++; $display("FAIL rmid_clean: got %h/%b want 83828180/1111", out_data, out_keep);
                end
            end
        end
        checks++;
        if (nb != 1) begin errors++; $display("FAIL rmid_count: got %0d want 1", nb); end
        do_reset();
    endtask

    task automatic test_random();
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(1, 0) == 1) push(DSIZE'($urandom));
            out_ready = ($urandom_range(3, 0) != 0);
            flush     = ($urandom_range(15, 0) == 0);
            tick();
        end
        flush     = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 20; c++) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int c = 0; c < 5; c++) tick();
        checks++;
        if (rempty !== 1'b1) begin errors++; $display("FAIL rand_drain: got rempty %b want 1", rempty); end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rand_idle: got valid %b want 0", out_valid); end
    endtask

    initial begin
        rrst_n = 1'b0;
        tick();
        tick();
        chk_en = 1'b1;
        test_reset();
        test_streaming();
        test_backpressure();
        test_partial_flush();
        test_empty_full_flush();
        test_flush_with_pop();
        test_reset_mid();
        test_random();
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
